apb_master_bridge: RTL and testbench

//  Converts single CPU read/write requests (valid/ready) into APB3 transfers
//  for the timer register block (TDR 0x00, TCR 0x01, TSR 0x02). It sits directly

---
 rtl/apb_master_bridge.sv | 124 ++++++++++++
 tb/tb_apb_master_bridge.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// Single-request CPU valid/ready to APB3 master bridge for the timer register block.
// One outstanding transfer; a one-cycle response pulse carries read data and the error flag.
module apb_master_bridge #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [7:0]        err_cnt,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t            state, state_nx;
  logic [TW-1:0]     to_cnt;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              accept, done, abort;

  always_ff @(posedge pclk) begin
    if (!presetn) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    accept    = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept   = 1'b1;
          state_nx = SETUP;
        end
      end
      SETUP: begin
        psel     = 1'b1;
        state_nx = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready) begin
          done     = 1'b1;
          state_nx = IDLE;
        end else if (TIMEOUT != 0 && to_cnt == TW'(TIMEOUT - 1)) begin
          // this is the TIMEOUT-th stalled ACCESS cycle
          abort    = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request fields double as the APB address/direction and hold while psel is low.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      wr_q    <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  assign pwrite = wr_q;
  assign paddr  = addr_q;
  assign pwdata = wr_q ? wdata_q : '0;

  always_ff @(posedge pclk) begin
    if (!presetn)                       to_cnt <= '0;
    else if (state == SETUP)            to_cnt <= '0;
    else if (state == ACCESS && !pready) to_cnt <= to_cnt + 1'b1;
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      rsp_valid <= done | abort;
      if (done) begin
        rsp_err   <= pslverr;
        rsp_rdata <= wr_q ? '0 : prdata;
      end else if (abort) begin
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
      if (((done && pslverr) || abort) && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: zero-wait, wait states, slave error,
// timeout abort, mid-transfer reset and back-to-back requests.
module tb_apb_master_bridge;

  logic       pclk = 1'b0;
  logic       presetn;
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata, err_cnt;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata, prdata;
  logic       pready, pslverr;

  int n_assert = 0;
  int n_fail   = 0;

  apb_master_bridge #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .err_cnt(err_cnt),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    presetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    prdata = 8'h00; pready = 1'b0; pslverr = 1'b0;
    tick(); tick();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    presetn = 1'b1;
    tick();

    // 1: zero-wait write 0x00 = 0xA5
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h00; req_wdata = 8'hA5; pready = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("t1_setup_psel", psel, 1);
    chk("t1_setup_penable", penable, 0);
    chk("t1_setup_pwrite", pwrite, 1);
    chk("t1_setup_pwdata", pwdata, 8'hA5);
    chk("t1_setup_ready", req_ready, 0);
    tick();
    chk("t1_access_psel", psel, 1);
    chk("t1_access_penable", penable, 1);
    chk("t1_access_rsp", rsp_valid, 0);
    tick();
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_err", rsp_err, 0);
    chk("t1_rsp_rdata", rsp_rdata, 0);
    chk("t1_rsp_psel", psel, 0);
    chk("t1_rsp_ready", req_ready, 1);
    pready = 1'b0;
    tick();
    chk("t1_pulse_end", rsp_valid, 0);
    chk("t1_paddr_hold", paddr, 8'h00);

    // 2: read 0x01 with 3 wait states; junk prdata/pslverr while not ready
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h01;
    tick();
    req_valid = 1'b0;
    chk("t2_setup_pwdata", pwdata, 0);
    chk("t2_setup_pwrite", pwrite, 0);
    tick();
    prdata = 8'hEE; pslverr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t2_wait_penable", penable, 1);
      chk("t2_wait_paddr", paddr, 8'h01);
      tick();
    end
    chk("t2_last_penable", penable, 1);
    pready = 1'b1; prdata = 8'hB3; pslverr = 1'b0;
    tick();
    pready = 1'b0; prdata = 8'h00;
    chk("t2_rsp_valid", rsp_valid, 1);
    chk("t2_rsp_rdata", rsp_rdata, 8'hB3);
    chk("t2_rsp_err", rsp_err, 0);
    tick();
    chk("t2_rdata_hold", rsp_rdata, 8'hB3);
    chk("t2_pulse_end", rsp_valid, 0);

    // 3: write 0x05 with slave error
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h05; req_wdata = 8'h77;
    tick();
    req_valid = 1'b0;
    tick();
    pready = 1'b1; pslverr = 1'b1; prdata = 8'h55;
    tick();
    pready = 1'b0; pslverr = 1'b0;
    chk("t3_rsp_valid", rsp_valid, 1);
    chk("t3_rsp_err", rsp_err, 1);
    chk("t3_rsp_rdata", rsp_rdata, 0);
    tick();
    chk("t3_err_cnt", err_cnt, 1);

    // 4: read 0x02, pready stuck low -> abort after 16 ACCESS cycles
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h02; prdata = 8'h99;
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("t4_access_penable", penable, 1);
      chk("t4_access_rsp", rsp_valid, 0);
      tick();
    end
    chk("t4_abort_psel", psel, 0);
    chk("t4_abort_penable", penable, 0);
    chk("t4_abort_rsp_valid", rsp_valid, 1);
    chk("t4_abort_rsp_err", rsp_err, 1);
    chk("t4_abort_rdata", rsp_rdata, 0);
    tick();
    chk("t4_err_cnt", err_cnt, 2);

    // 5: reset during ACCESS drops the transfer
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h01; req_wdata = 8'h11;
    tick();
    req_valid = 1'b0;
    tick();
    chk("t5_in_access", penable, 1);
    presetn = 1'b0;
    tick();
    chk("t5_psel", psel, 0);
    chk("t5_penable", penable, 0);
    chk("t5_rsp_valid", rsp_valid, 0);
    presetn = 1'b1;
    tick();
    chk("t5_rsp_after", rsp_valid, 0);
    chk("t5_ready", req_ready, 1);
    chk("t5_err_cnt", err_cnt, 0);

    // 6: back-to-back write 0x00=0x3C then read 0x00
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h00; req_wdata = 8'h3C;
    pready = 1'b1; prdata = 8'h3C;
    tick();
    req_write = 1'b0;
    chk("t6_w_setup_pwdata", pwdata, 8'h3C);
    tick();
    tick();
    chk("t6_w_rsp_valid", rsp_valid, 1);
    chk("t6_gap_psel", psel, 0);
    chk("t6_gap_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("t6_r_setup_psel", psel, 1);
    chk("t6_r_setup_pwrite", pwrite, 0);
    chk("t6_r_setup_rsp", rsp_valid, 0);
    tick();
    chk("t6_r_access", penable, 1);
    tick();
    pready = 1'b0;
    chk("t6_r_rsp_valid", rsp_valid, 1);
    chk("t6_r_rdata", rsp_rdata, 8'h3C);
    chk("t6_r_err", rsp_err, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
